dmem_ctrl: RTL and testbench

Data-memory controller that sits directly downstream of the RV64IFD core's load/store address/data outputs and produces its load-data input. It owns a single-port 64-bit-wide SRAM array without byte enables. Sub-doubleword stores therefore run a read-modify-write sequence. Loads are size-selected and sign/zero-extended, and every access uses a one-deep request/response handshake.

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_sram_array.sv | 24 ++
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: FSM state encoding,
// access-size constants and byte-lane mask/alignment helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Low lane bits that must be zero for an access of this size to be aligned.
  function automatic logic [2:0] size_low_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      SZ_B:    m = 3'b000;
      SZ_H:    m = 3'b001;
      SZ_W:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-side request/response bundle of the data-memory controller.
// Handshake: a request is taken on a rising edge where in_req && out_ready; out_ready
// then stays low until the access has finished, and out_valid pulses for exactly one
// cycle carrying out_rd_data/out_err. in_req is ignored while out_ready is low.
interface dmem_if;
  logic        in_req;
  logic        in_wr_en;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [63:0] in_addr;
  logic [63:0] in_wr_data;
  logic        out_ready;
  logic        out_valid;
  logic [63:0] out_rd_data;
  logic        out_err;

  modport master (
    output in_req, in_wr_en, in_size, in_unsigned, in_addr, in_wr_data,
    input  out_ready, out_valid, out_rd_data, out_err
  );

  modport slave (
    input  in_req, in_wr_en, in_size, in_unsigned, in_addr, in_wr_data,
    output out_ready, out_valid, out_rd_data, out_err
  );
endinterface

// File: rtl/dmem_sram_array.sv
// Single-port 64-bit SRAM without byte enables; read data is registered and only
// changes on a cycle where in_rd_en is asserted.
module dmem_sram_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  in_Clk,
  input  logic                  in_rd_en,
  input  logic                  in_wr_en,
  input  logic [DEPTH_LOG2-1:0] in_idx,
  input  logic [63:0]           in_wr_data,
  output logic [63:0]           out_rd_data
);

  logic [63:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [63:0] rd_q;

  always_ff @(posedge in_Clk) begin
    if (in_wr_en) mem_q[in_idx] <= in_wr_data;
    if (in_rd_en) rd_q <= mem_q[in_idx];
  end

  assign out_rd_data = rd_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one access at a time, read-modify-write for sub-doubleword
// stores, size-selected sign/zero-extended loads. DMEM_MISALIGN_TRAP_EN turns
// misaligned accesses into faults instead of silently aligning them down.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input  logic   in_Clk,
  input  logic   in_Rst,
  dmem_if.slave  bus,
  output state_e out_dbg_state
);

  state_e                state_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [2:0]            lane_q;
  logic [1:0]            size_q;
  logic                  wr_q;
  logic                  uns_q;
  logic                  flt_q;
  logic [63:0]           wdata_q;
  logic                  ready_q;
  logic                  valid_q;
  logic                  oerr_q;
  logic [63:0]           rd_hold_q;

  logic [63:0]           acc_off;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [2:0]            raw_lane;
  logic [2:0]            acc_lane;
  logic                  acc_range_err;
  logic                  acc_fault;

  logic [63:0]           sram_rdata;
  logic [63:0]           rd_shift;
  logic [63:0]           ext_data;
  logic [63:0]           resp_data;
  logic [7:0]            wr_mask;
  logic [63:0]           wr_shift;
  logic [63:0]           merged;

  // Decode of the incoming request, used only on the accept edge.
  always_comb begin
    acc_off       = bus.in_addr - BASE_ADDR;
    acc_idx       = acc_off[DEPTH_LOG2+2:3];
    raw_lane      = acc_off[2:0];
    acc_range_err = (acc_off >> (DEPTH_LOG2 + 3)) != 64'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
    acc_lane      = raw_lane;
    acc_fault     = acc_range_err || ((raw_lane & size_low_mask(bus.in_size)) != 3'd0);
`else
    acc_lane      = raw_lane & ~size_low_mask(bus.in_size);
    acc_fault     = acc_range_err;
`endif
  end

  dmem_sram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .in_Clk      (in_Clk),
    .in_rd_en    (state_q == ST_READ),
    .in_wr_en    (state_q == ST_WRITE),
    .in_idx      (idx_q),
    .in_wr_data  (merged),
    .out_rd_data (sram_rdata)
  );

  // A full doubleword store has an all-ones mask, so the stale read word never leaks in.
  always_comb begin
    wr_mask  = lane_mask(size_q, lane_q);
    wr_shift = wdata_q << {lane_q, 3'b000};
    merged   = sram_rdata;
    for (int i = 0; i < 8; i++) begin
      if (wr_mask[i]) merged[8*i +: 8] = wr_shift[8*i +: 8];
    end
  end

  always_comb begin
    rd_shift = sram_rdata >> {lane_q, 3'b000};
    ext_data = rd_shift;
    case (size_q)
      SZ_B:    ext_data = uns_q ? {56'd0, rd_shift[7:0]}  : {{56{rd_shift[7]}},  rd_shift[7:0]};
      SZ_H:    ext_data = uns_q ? {48'd0, rd_shift[15:0]} : {{48{rd_shift[15]}}, rd_shift[15:0]};
      SZ_W:    ext_data = uns_q ? {32'd0, rd_shift[31:0]} : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: ext_data = rd_shift;
    endcase
    resp_data = (wr_q || flt_q) ? 64'd0 : ext_data;
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      lane_q    <= 3'd0;
      size_q    <= SZ_B;
      wr_q      <= 1'b0;
      uns_q     <= 1'b0;
      flt_q     <= 1'b0;
      wdata_q   <= 64'd0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      oerr_q    <= 1'b0;
      rd_hold_q <= 64'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_req && ready_q) begin
            idx_q   <= acc_idx;
            lane_q  <= acc_lane;
            size_q  <= bus.in_size;
            wr_q    <= bus.in_wr_en;
            uns_q   <= bus.in_unsigned;
            flt_q   <= acc_fault;
            wdata_q <= bus.in_wr_data;
            ready_q <= 1'b0;
            if (acc_fault) begin
              state_q <= ST_RESP;
              valid_q <= 1'b1;
              oerr_q  <= 1'b1;
            end else if (bus.in_wr_en && (bus.in_size == SZ_D)) begin
              state_q <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state_q <= wr_q ? ST_WRITE : ST_RESP;
          valid_q <= !wr_q;
          oerr_q  <= 1'b0;
        end
        ST_WRITE: begin
          state_q <= ST_RESP;
          valid_q <= 1'b1;
          oerr_q  <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b1;
          valid_q   <= 1'b0;
          oerr_q    <= 1'b0;
          rd_hold_q <= resp_data;
        end
      endcase
    end
  end

  // Response data is formed from the registered array word during RESP, then held.
  assign bus.out_rd_data = (state_q == ST_RESP) ? resp_data : rd_hold_q;
  assign bus.out_ready   = ready_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_err     = oerr_q;
  assign out_dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed accesses plus randomized traffic against
// a byte-addressed memory model. Honours DMEM_MISALIGN_TRAP_EN when it is defined.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int          DL2  = 10;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic   clk;
  logic   rst;
  state_e dbg;
  dmem_if bus ();

  dmem_ctrl #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE)) dut (
    .in_Clk        (clk),
    .in_Rst        (rst),
    .bus           (bus),
    .out_dbg_state (dbg)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  mem_b [0:1023];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_access(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wd,
                              output logic [63:0] ed, output logic ee, output int el);
    logic [63:0] off;
    logic [63:0] v;
    int n, lane, ba;
    bit fault;
    off   = addr - BASE;
    n     = 1 << sz;
    lane  = int'(off[2:0]);
    fault = (off >> 13) != 64'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((lane % n) != 0) fault = 1'b1;
`else
    lane = lane - (lane % n);
`endif
    ed = 64'd0;
    ee = 1'b0;
    if (fault) begin
      ee = 1'b1;
      el = 0;
    end else begin
      ba = int'(off[9:3]) * 8 + lane;
      if (wr) begin
        for (int i = 0; i < n; i++) mem_b[ba+i] = wd[8*i +: 8];
        el = (n == 8) ? 1 : 2;
      end else begin
        v = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[ba+i];
        if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        ed = v;
        el = 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic access(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] off, input logic [63:0] wd, input bit hold,
                        output logic [63:0] rd, output logic er);
    logic [63:0] ed;
    logic        ee;
    int          el;
    int          lat;
    model_access(wr, sz, uns, BASE + off, wd, ed, ee, el);
    exp_q.push_back(ed);
    @(negedge clk);
    check_eq("ready_before_req", bus.out_ready, 1);
    bus.in_wr_en    = wr;
    bus.in_size     = sz;
    bus.in_unsigned = uns;
    bus.in_addr     = BASE + off;
    bus.in_wr_data  = wd;
    bus.in_req      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.in_req = 1'b0;
    check_eq("ready_busy", bus.out_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 16) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", lat, el);
    rd = bus.out_rd_data;
    er = bus.out_err;
    check_eq("err", er, ee);
    check_eq("rd_data", rd, exp_q.pop_front());
    @(negedge clk);
    bus.in_req = 1'b0;
    @(posedge clk);
    #1;
    check_eq("valid_one_cycle", bus.out_valid, 0);
    check_eq("ready_after", bus.out_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] rd;
  logic        er;
  logic [63:0] roff;

  initial begin
    rst             = 1'b1;
    bus.in_req      = 1'b0;
    bus.in_wr_en    = 1'b0;
    bus.in_size     = SZ_B;
    bus.in_unsigned = 1'b0;
    bus.in_addr     = 64'd0;
    bus.in_wr_data  = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", bus.out_ready, 1);
    check_eq("rst_valid", bus.out_valid, 0);
    check_eq("rst_rd_data", bus.out_rd_data, 0);
    check_eq("rst_err", bus.out_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Give the tested region defined contents.
    for (int i = 0; i < 128; i++) access(1'b1, SZ_D, 1'b0, 64'(i * 8), {$urandom, $urandom}, 1'b0, rd, er);

    access(1'b1, SZ_D, 1'b0, 64'h10, 64'h8877665544332211, 1'b0, rd, er);
    access(1'b0, SZ_D, 1'b0, 64'h10, 64'd0, 1'b0, rd, er);
    check_eq("tp_ld_10", rd, 64'h8877665544332211);
    access(1'b1, SZ_B, 1'b0, 64'h13, 64'h00000000000000FF, 1'b0, rd, er);
    access(1'b0, SZ_D, 1'b0, 64'h10, 64'd0, 1'b0, rd, er);
    check_eq("tp_ld_after_sb", rd, 64'h88776655FF332211);
    access(1'b0, SZ_B, 1'b0, 64'h13, 64'd0, 1'b0, rd, er);
    check_eq("tp_lb", rd, 64'hFFFFFFFFFFFFFFFF);
    access(1'b0, SZ_B, 1'b1, 64'h13, 64'd0, 1'b0, rd, er);
    check_eq("tp_lbu", rd, 64'h00000000000000FF);
    access(1'b0, SZ_W, 1'b0, 64'h14, 64'd0, 1'b0, rd, er);
    check_eq("tp_lw", rd, 64'hFFFFFFFF88776655);
    access(1'b0, SZ_W, 1'b1, 64'h14, 64'd0, 1'b0, rd, er);
    check_eq("tp_lwu", rd, 64'h0000000088776655);
    access(1'b0, SZ_H, 1'b0, 64'h16, 64'd0, 1'b0, rd, er);
    check_eq("tp_lh", rd, 64'hFFFFFFFFFFFF8877);

    // Range fault aliasing index 0 must not write.
    access(1'b1, SZ_D, 1'b0, 64'h2000, 64'hDEADBEEFCAFEF00D, 1'b0, rd, er);
    check_eq("tp_range_err", er, 1);
    access(1'b0, SZ_D, 1'b0, 64'h0, 64'd0, 1'b0, rd, er);
    access(1'b0, SZ_D, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0, rd, er);
    check_eq("tp_below_base_err", er, 1);

    access(1'b0, SZ_W, 1'b0, 64'h12, 64'd0, 1'b0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check_eq("tp_misalign_err", er, 1);
    check_eq("tp_misalign_data", rd, 64'd0);
`else
    check_eq("tp_misalign_err", er, 0);
    check_eq("tp_misalign_data", rd, 64'hFFFFFFFFFF332211);
`endif

    // Reset while an SB sits in WRITE: the store must not land.
    @(negedge clk);
    bus.in_wr_en    = 1'b1;
    bus.in_size     = SZ_B;
    bus.in_unsigned = 1'b0;
    bus.in_addr     = BASE + 64'h10;
    bus.in_wr_data  = 64'h0;
    bus.in_req      = 1'b1;
    @(posedge clk);
    #1;
    bus.in_req = 1'b0;
    @(posedge clk);
    #1;
    check_eq("sb_in_write_state", dbg, ST_WRITE);
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", bus.out_ready, 1);
    check_eq("midrst_valid", bus.out_valid, 0);
    check_eq("midrst_err", bus.out_err, 0);
    check_eq("midrst_rd_data", bus.out_rd_data, 0);
    check_eq("midrst_state", dbg, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, SZ_D, 1'b0, 64'h10, 64'd0, 1'b0, rd, er);
    check_eq("tp_no_commit_after_rst", rd, 64'h88776655FF332211);

    // in_req held high while busy must give a single response.
    access(1'b1, SZ_H, 1'b0, 64'h22, 64'h000000000000ABCD, 1'b1, rd, er);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_eq("hold_no_second_valid", bus.out_valid, 0);
      check_eq("hold_idle", dbg, ST_IDLE);
    end
    access(1'b0, SZ_H, 1'b1, 64'h22, 64'd0, 1'b0, rd, er);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        roff = {$urandom, $urandom};
        if ((roff >> 13) == 64'd0) roff = roff | 64'h0000_0001_0000_0000;
      end else begin
        roff = 64'($urandom_range(0, 1023));
      end
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             roff, {$urandom, $urandom}, ($urandom_range(0, 3) == 0), rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
